// File: rtl/con_mdr_pcinc.sv
// Datapath helpers: conditional-branch flag (CON FF), memory data register
// with bus/memory source select, and a registered PC+1 incrementer.
module con_mdr_pcinc (
    input  logic        clk,
    input  logic        clr,
    input  logic        CONin,
    input  logic [31:0] IR,
    input  logic [31:0] BusMuxOut,
    input  logic        MDRin,
    input  logic        Read,
    input  logic [31:0] Mdatain,
    input  logic        IncPC,
    input  logic [31:0] PC,
    output logic        con_out,
    output logic [31:0] MDR_q,
    output logic [31:0] PC_inc
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] COND_ZERO    = 2'b00;
    localparam logic [1:0] COND_NONZERO = 2'b01;
    localparam logic [1:0] COND_POS     = 2'b10;
    localparam logic [1:0] COND_NEG     = 2'b11;

    logic [1:0]        w_c2;
    logic              w_bus_zero;
    logic              w_bus_sign;
    logic              w_cond;
    logic [DATA_W-1:0] w_mdr_d;
    logic [DATA_W-1:0] w_pc_next;
    logic              w_unused_ir;

    logic              r_con;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_pc_inc;

    // Only the C2 field of the instruction matters to this block.
    assign w_c2        = IR[20:19];
    assign w_unused_ir = ^{IR[31:21], IR[18:0]};

    assign w_bus_zero = (BusMuxOut == '0);
    assign w_bus_sign = BusMuxOut[DATA_W-1];

    always_comb begin
        w_cond = 1'b0;
        case (w_c2)
            COND_ZERO:    w_cond = w_bus_zero;
            COND_NONZERO: w_cond = !w_bus_zero;
            COND_POS:     w_cond = !w_bus_sign;
            COND_NEG:     w_cond = w_bus_sign;
            default:      w_cond = 1'b0;
        endcase
    end

    assign w_mdr_d   = Read ? Mdatain : BusMuxOut;
    assign w_pc_next = PC + DATA_W'(1);

    // Three independent load-enabled registers sharing one async clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_con    <= 1'b0;
            r_mdr    <= '0;
            r_pc_inc <= '0;
        end else begin
            if (CONin) begin
                r_con <= w_cond;
            end
            if (MDRin) begin
                r_mdr <= w_mdr_d;
            end
            if (IncPC) begin
                r_pc_inc <= w_pc_next;
            end
        end
    end

    assign con_out = r_con;
    assign MDR_q   = r_mdr;
    assign PC_inc  = r_pc_inc;

endmodule

// File: tb/tb_con_mdr_pcinc.sv
// Randomized bench for con_mdr_pcinc against a behavioural model, plus
// directed cases with literal expected values.
module tb_con_mdr_pcinc;

    logic        clk;
    logic        clr;
    logic        CONin;
    logic [31:0] IR;
    logic [31:0] BusMuxOut;
    logic        MDRin;
    logic        Read;
    logic [31:0] Mdatain;
    logic        IncPC;
    logic [31:0] PC;
    logic        con_out;
    logic [31:0] MDR_q;
    logic [31:0] PC_inc;

    int checks = 0;
    int errors = 0;

    logic        m_con;
    logic [31:0] m_mdr;
    logic [31:0] m_pc;

    con_mdr_pcinc dut (
        .clk       (clk),
        .clr       (clr),
        .CONin     (CONin),
        .IR        (IR),
        .BusMuxOut (BusMuxOut),
        .MDRin     (MDRin),
        .Read      (Read),
        .Mdatain   (Mdatain),
        .IncPC     (IncPC),
        .PC        (PC),
        .con_out   (con_out),
        .MDR_q     (MDR_q),
        .PC_inc    (PC_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cond_of(input logic [1:0] c2, input logic [31:0] bus);
        int signed sv;
        sv = $signed(bus);
        case (c2)
            2'd0:    return bus == 32'd0;
            2'd1:    return bus != 32'd0;
            2'd2:    return sv >= 0;
            default: return sv < 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("con_out", {31'd0, con_out}, {31'd0, m_con});
        check("MDR_q", MDR_q, m_mdr);
        check("PC_inc", PC_inc, m_pc);
    endtask

    // Apply the model's view of one rising edge, then compare just after it.
    task automatic step();
        @(posedge clk);
        if (clr) begin
            if (CONin) m_con = cond_of(IR[20:19], BusMuxOut);
            if (MDRin) m_mdr = Read ? Mdatain : BusMuxOut;
            if (IncPC) m_pc = PC + 32'd1;
        end
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        CONin = 0; MDRin = 0; Read = 0; IncPC = 0;
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_inputs();
        CONin     = 1'($urandom_range(0, 1));
        MDRin     = 1'($urandom_range(0, 1));
        Read      = 1'($urandom_range(0, 1));
        IncPC     = 1'($urandom_range(0, 1));
        IR        = $urandom;
        BusMuxOut = pick_data();
        Mdatain   = pick_data();
        PC        = pick_data();
    endtask

    task automatic reset_pulse();
        clr = 1'b0;
        m_con = 0; m_mdr = '0; m_pc = '0;
        #1;
        check_model();
        random_inputs();
        step();
        @(negedge clk);
        clr = 1'b1;
    endtask

    logic [1:0]  con_code [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] con_bus  [5] = '{32'd0, 32'd0, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF};
    logic        con_exp  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        clr = 1'b1;
        idle_inputs();
        IR = '0; BusMuxOut = '0; Mdatain = '0; PC = '0;
        m_con = 0; m_mdr = '0; m_pc = '0;

        // Reset mid-cycle with all enables high and nonzero data.
        #2;
        CONin = 1; MDRin = 1; IncPC = 1; Read = 0;
        IR = 32'h0018_0000; BusMuxOut = 32'hA5A5_A5A5; Mdatain = 32'h1357_9BDF; PC = 32'h42;
        clr = 1'b0;
        #1;
        check("rst_con", {31'd0, con_out}, 32'd0);
        check("rst_mdr", MDR_q, 32'd0);
        check("rst_pc", PC_inc, 32'd0);
        step();
        @(negedge clk);
        clr = 1'b1;
        idle_inputs();
        MDRin = 1; Read = 0; BusMuxOut = 32'h1234_5678;
        step();
        check("mdr_after_rst", MDR_q, 32'h1234_5678);

        // MDR select and hold.
        MDRin = 1; Read = 1; Mdatain = 32'hDEAD_BEEF; BusMuxOut = 32'h1111_1111;
        step();
        check("mdr_mem", MDR_q, 32'hDEAD_BEEF);
        MDRin = 0; Mdatain = 32'h0BAD_F00D;
        step();
        check("mdr_hold", MDR_q, 32'hDEAD_BEEF);

        // CON decode table with random don't-care IR bits.
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            CONin = 1;
            IR = $urandom;
            IR[20:19] = con_code[i];
            BusMuxOut = con_bus[i];
            step();
            check("con_decode", {31'd0, con_out}, {31'd0, con_exp[i]});
        end

        // CON hold with a false condition presented.
        IR[20:19] = 2'd0; BusMuxOut = 32'd0;
        step();
        check("con_set", {31'd0, con_out}, 32'd1);
        CONin = 0; BusMuxOut = 32'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            check("con_hold", {31'd0, con_out}, 32'd1);
        end

        // PC increment, wrap, and hold.
        IncPC = 1; PC = 32'h10;
        step();
        check("pc_inc", PC_inc, 32'h11);
        PC = 32'hFFFF_FFFF;
        step();
        check("pc_wrap", PC_inc, 32'h0);
        IncPC = 0; PC = 32'h55;
        step();
        PC = 32'h99;
        step();
        check("pc_hold", PC_inc, 32'h0);

        // All three units loading on the same edge.
        CONin = 1; MDRin = 1; IncPC = 1; Read = 0;
        IR = 32'h0018_0000; BusMuxOut = 32'h8000_0000; PC = 32'h1234;
        step();
        check("conc_con", {31'd0, con_out}, 32'd1);
        check("conc_mdr", MDR_q, 32'h8000_0000);
        check("conc_pc", PC_inc, 32'h1235);

        // Randomized run with occasional mid-cycle resets and glitching data.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_pulse();
            end else begin
                random_inputs();
                #2;
                BusMuxOut = pick_data();
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/con_mdr_pcinc.md
# con_mdr_pcinc

Bundles the three small datapath helper units of the CPU: the conditional-branch flag (CON FF), the memory data register (MDR) with its bus/memory input select, and the PC incrementer. It sits beside the bus mux and ALU. It consumes the instruction register, the bus value, memory read data and the current PC, and returns a branch-taken flag, the MDR contents and PC+1 to the datapath.

## Interface
Parameters:
- none (all data paths fixed at 32 bits)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- clr  in  1  reset, asynchronous, active-low; clears every register in the block
- CONin  in  1  load enable for the CON flip-flop
- IR  in  32  current instruction; IR[20:19] is the branch condition code C2
- BusMuxOut  in  32  current bus value; compared for CON and used as MDR bus-side source
- MDRin  in  1  MDR load enable
- Read  in  1  MDR source select: 1 = Mdatain (memory), 0 = BusMuxOut
- Mdatain  in  32  memory read data
- IncPC  in  1  PC increment enable
- PC  in  32  current program counter value
- con_out  out  1  registered branch-condition result
- MDR_q  out  32  MDR contents (drives bus mux input and RAM write data)
- PC_inc  out  32  registered PC+1 result (feeds Z register input)

## Operation
- CON FF:
  - Condition decode on BusMuxOut using IR[20:19]:
    - 00 = zero: BusMuxOut == 0.
    - 01 = nonzero: BusMuxOut != 0.
    - 10 = positive: BusMuxOut[31] == 0 (zero counts as positive).
    - 11 = negative: BusMuxOut[31] == 1.
  - Other IR bits are ignored.
  - When CONin=1 at a rising edge, con_out takes the decoded result; otherwise it holds.
- MDR:
  - Input mux selects Mdatain when Read=1, else BusMuxOut.
  - When MDRin=1 at a rising edge, MDR_q takes the mux output; otherwise it holds.
  - Read without MDRin has no effect.
- PC incrementer:
  - When IncPC=1 at a rising edge, PC_inc takes PC + 1, unsigned modulo 2^32.
  - When IncPC=0, PC_inc holds.
  - The block never writes PC itself; the datapath loads PC from the bus.
- The three units are independent; any combination of enables may be active in the same cycle.
- No combinational path from any input to any output; all outputs are registered.

## Timing
- Reset:
  - clr=0 asynchronously forces con_out=0, MDR_q=0x00000000 and PC_inc=0x00000000, without waiting for a clock edge.
  - While clr=0, all enables are ignored.
  - The first load occurs on the first rising edge after clr returns to 1.
- Latency: 1 clock for every unit. The value sampled at edge N is visible on the output after edge N.
- Inputs are sampled only at the rising edge; changes to BusMuxOut, IR, PC or Mdatain between edges do not affect outputs.
- Wrap-around: PC=0xFFFFFFFF with IncPC=1 gives PC_inc=0x00000000.
- Reset asserted mid-operation (same cycle as an enable): reset wins, outputs read 0.

## Test plan
- Reset: drive all enables high with nonzero data, pulse clr=0 between edges -> con_out=0, MDR_q=0, PC_inc=0 immediately; after release and one edge with MDRin=1, Read=0, BusMuxOut=0x12345678 -> MDR_q=0x12345678.
- MDR select: MDRin=1, Read=1, Mdatain=0xDEADBEEF, BusMuxOut=0x11111111 -> MDR_q=0xDEADBEEF after one edge; then MDRin=0 and change Mdatain -> MDR_q unchanged.
- CON decode, each with CONin=1, one edge:
  - IR[20:19]=00, bus=0 -> 1
  - IR[20:19]=01, bus=0 -> 0
  - IR[20:19]=10, bus=0x00000005 -> 1
  - IR[20:19]=11, bus=0x80000000 -> 1
  - IR[20:19]=11, bus=0x7FFFFFFF -> 0
- CON hold: after con_out=1, set CONin=0 and bus so the condition is false -> con_out stays 1 across several edges.
- PC increment: PC=0x00000010, IncPC=1 -> PC_inc=0x00000011. PC=0xFFFFFFFF -> PC_inc=0x00000000. IncPC=0 with PC changing -> PC_inc holds.
- Concurrency: CONin, MDRin and IncPC all high in one cycle -> all three outputs update on the same edge with independent correct values.
